cam_bin_writer: RTL

- Upstream feeder of the 1-bit frame-buffer SDPB (17-bit address, 1-bit data, 81920 entries).
- Takes the camera DVP byte stream (RGB565, two bytes per pixel), computes luma and thresholds it to 1 bit.
- Generates the write-port signals (ce, address, din), cropped to the active window, plus a frame-complete pulse for the LCD read side.

---
 rtl/cam_bin_pkg.sv | 17 +
 rtl/rgb565_luma_bin.sv | 33 +++
 rtl/cam_bin_writer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cam_bin_pkg.sv
// Shared types and constants for the camera-to-1-bit frame-buffer writer.
package cam_bin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_CAPTURE    = 2'd2
    } cam_state_e;

    // BT.601-style luma weights scaled by 256; they sum to 256 so y fits 8 bits.
    localparam logic [15:0] LUMA_R = 16'd77;
    localparam logic [15:0] LUMA_G = 16'd150;
    localparam logic [15:0] LUMA_B = 16'd29;

    localparam int FB_DEPTH = 81920;

endpackage

// File: rtl/rgb565_luma_bin.sv
// RGB565 pixel to 8-bit luma, compared against a threshold; one register stage.
module rgb565_luma_bin
    import cam_bin_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_pixel,
    input  logic [7:0]  i_thr,
    output logic        o_din
);

    logic [7:0]  w_r8;
    logic [7:0]  w_g8;
    logic [7:0]  w_b8;
    logic [15:0] w_sum;

    always_comb begin
        w_r8  = {i_pixel[15:11], i_pixel[15:13]};
        w_g8  = {i_pixel[10:5],  i_pixel[10:9]};
        w_b8  = {i_pixel[4:0],   i_pixel[4:2]};
        w_sum = LUMA_R * {8'd0, w_r8} + LUMA_G * {8'd0, w_g8} + LUMA_B * {8'd0, w_b8};
    end

    // (sum >> 8) >= thr is the same test as sum >= thr*256
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_din <= 1'b0;
        end else begin
            o_din <= (w_sum >= {i_thr, 8'd0});
        end
    end

endmodule

// File: rtl/cam_bin_writer.sv
// DVP RGB565 stream to binarized SDPB write port, cropped to H_ACTIVE x V_ACTIVE.
// Optional macro CAM_BIN_FRAME_SKIP_EN: write only every second frame (first frame after reset skipped).
module cam_bin_writer
    import cam_bin_pkg::*;
#(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int ADDR_W   = 17
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    input  logic [7:0]        threshold,
    output logic              wr_ce,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_din,
    output logic              frame_done,
    output logic              frame_err
);

    // state      | meaning
    // IDLE       | after reset, waiting for vsync high
    // WAIT_START | vsync seen, waiting for its falling edge
    // CAPTURE    | frame active, pixels assembled and written

    localparam int COL_W = $clog2(H_ACTIVE + 1);
    localparam int ROW_W = $clog2(V_ACTIVE + 1);
    localparam logic [COL_W-1:0]  H_LIM  = COL_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0]  V_LIM  = ROW_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] A_LINE = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    cam_state_e        r_state;
    logic              r_vsync_q;
    logic              r_href_q;
    logic              r_phase;
    logic [7:0]        r_byte0;
    logic [7:0]        r_thr_q;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_line_base;
    logic              r_err;
    logic [15:0]       r_pix;
    logic              r_s1_keep;
    logic [ADDR_W-1:0] r_s1_addr;
    logic              r_s2_keep;
    logic [ADDR_W-1:0] r_s2_addr;
    logic              r_wr_ce;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_wr_din;
    logic              r_done;

    logic w_cap;
    logic w_vs_fall;
    logic w_vs_rise;
    logic w_pix;
    logic w_href_fall;
    logic w_keep;
    logic w_wr_en;
    logic w_din;

`ifdef CAM_BIN_FRAME_SKIP_EN
    logic r_odd_frame;
    assign w_wr_en = ~r_odd_frame;
`else
    assign w_wr_en = 1'b1;
`endif

    assign w_cap       = (r_state == ST_CAPTURE);
    assign w_vs_fall   = r_vsync_q & ~cam_vsync;
    assign w_vs_rise   = ~r_vsync_q & cam_vsync;
    assign w_pix       = w_cap & cam_href & r_phase;
    assign w_href_fall = w_cap & r_href_q & ~cam_href;
    assign w_keep      = w_pix & (r_col != H_LIM) & (r_row != V_LIM) & w_wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_vsync_q   <= 1'b0;
            r_href_q    <= 1'b0;
            r_phase     <= 1'b0;
            r_byte0     <= '0;
            r_thr_q     <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_addr      <= '0;
            r_line_base <= '0;
            r_err       <= 1'b0;
`ifdef CAM_BIN_FRAME_SKIP_EN
            r_odd_frame <= 1'b0;
`endif
        end else begin
            r_vsync_q <= cam_vsync;
            r_href_q  <= cam_href;
            case (r_state)
                ST_IDLE: begin
                    if (cam_vsync) r_state <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (w_vs_fall) begin
                        r_state     <= ST_CAPTURE;
                        r_thr_q     <= threshold;
                        r_col       <= '0;
                        r_row       <= '0;
                        r_addr      <= '0;
                        r_line_base <= '0;
                        r_phase     <= 1'b0;
`ifdef CAM_BIN_FRAME_SKIP_EN
                        r_odd_frame <= ~r_odd_frame;
`endif
                    end
                end
                ST_CAPTURE: begin
                    r_phase <= cam_href & ~r_phase;
                    if (cam_href && !r_phase) r_byte0 <= cam_data;
                    if (w_pix && r_col != H_LIM) r_col <= r_col + COL_W'(1);
                    if (w_keep) r_addr <= r_addr + ADDR_W'(1);
                    // row/col saturate at the window edge so cropped pixels never advance the address
                    if (w_href_fall) begin
                        r_col <= '0;
                        if (r_col != '0 && r_row != V_LIM) begin
                            r_row       <= r_row + ROW_W'(1);
                            r_line_base <= r_line_base + A_LINE;
                            r_addr      <= r_line_base + A_LINE;
                            if (r_col != H_LIM) r_err <= 1'b1;
                        end
                    end
                    if (w_vs_rise) begin
                        r_state <= ST_WAIT_START;
                        if (r_row != V_LIM) r_err <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    rgb565_luma_bin u_luma (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pixel (r_pix),
        .i_thr   (r_thr_q),
        .o_din   (w_din)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix     <= '0;
            r_s1_keep <= 1'b0;
            r_s1_addr <= '0;
            r_s2_keep <= 1'b0;
            r_s2_addr <= '0;
            r_wr_ce   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_din  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (w_pix) r_pix <= {r_byte0, cam_data};
            r_s1_keep <= w_keep;
            if (w_keep) r_s1_addr <= r_addr;
            r_s2_keep <= r_s1_keep;
            r_s2_addr <= r_s1_addr;
            r_wr_ce   <= r_s2_keep;
            if (r_s2_keep) r_wr_addr <= r_s2_addr;
            r_wr_din  <= r_s2_keep & w_din;
            r_done    <= r_wr_ce && (r_wr_addr == A_LAST);
        end
    end

    assign wr_ce      = r_wr_ce;
    assign wr_addr    = r_wr_addr;
    assign wr_din     = r_wr_din;
    assign frame_done = r_done;
    assign frame_err  = r_err;

endmodule
